// File: rtl/rv32v_simd_multiplier.sv
// Lane-partitioned (SEW 8/16/32) pipelined integer multiplier with stall and tag passthrough.
// Optional full-width lane products on product_wide when RV32V_MUL_WIDEN_EN is defined.
module rv32v_simd_multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 3,
    parameter int TAG_W      = 5
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    start,
    input  logic                    stall,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    input  logic [1:0]              is_signed,
    input  logic [1:0]              sew,
    input  logic                    high_half,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    finished,
    output logic [DATA_WIDTH-1:0]   product,
    output logic [TAG_W-1:0]        tag_out
`ifdef RV32V_MUL_WIDEN_EN
    ,
    output logic [2*DATA_WIDTH-1:0] product_wide
`endif
);

    localparam int DW = DATA_WIDTH;

    logic [2*DW-1:0] wide8, wide16, wide32;
    logic [DW-1:0]   half8, half16, half32, half_sel;
    logic [15:0]     a8, b8;
    logic [31:0]     a16, b16;
    logic [63:0]     a32, b32;

    // Each lane operand is extended to 2*SEW bits, so the low 2*SEW bits of a plain
    // multiply are the exact signed/unsigned product and nothing leaks across lanes.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        wide8  = '0;
        wide16 = '0;
        wide32 = '0;
        a8  = '0;
        b8  = '0;
        a16 = '0;
        b16 = '0;
        a32 = '0;
        b32 = '0;
        for (int i = 0; i < DW/8; i++) begin
            a8 = {{8{is_signed[1] & multiplicand[i*8+7]}}, multiplicand[i*8 +: 8]};
            b8 = {{8{is_signed[0] & multiplier[i*8+7]}}, multiplier[i*8 +: 8]};
            wide8[i*16 +: 16] = a8 * b8;
        end
        for (int i = 0; i < DW/16; i++) begin
            a16 = {{16{is_signed[1] & multiplicand[i*16+15]}}, multiplicand[i*16 +: 16]};
            b16 = {{16{is_signed[0] & multiplier[i*16+15]}}, multiplier[i*16 +: 16]};
            wide16[i*32 +: 32] = a16 * b16;
        end
        for (int i = 0; i < DW/32; i++) begin
            a32 = {{32{is_signed[1] & multiplicand[i*32+31]}}, multiplicand[i*32 +: 32]};
            b32 = {{32{is_signed[0] & multiplier[i*32+31]}}, multiplier[i*32 +: 32]};
            wide32[i*64 +: 64] = a32 * b32;
        end
    end

`ifdef RV32V_MUL_WIDEN_EN
    logic [2*DW-1:0] wide_sel;
`endif

    always_comb begin
        half8  = '0;
        half16 = '0;
        half32 = '0;
        for (int i = 0; i < DW/8; i++)
            half8[i*8 +: 8] = high_half ? wide8[i*16+8 +: 8] : wide8[i*16 +: 8];
        for (int i = 0; i < DW/16; i++)
            half16[i*16 +: 16] = high_half ? wide16[i*32+16 +: 16] : wide16[i*32 +: 16];
        for (int i = 0; i < DW/32; i++)
            half32[i*32 +: 32] = high_half ? wide32[i*64+32 +: 32] : wide32[i*64 +: 32];
        case (sew)
            2'b00:   half_sel = half8;
            2'b01:   half_sel = half16;
            default: half_sel = half32;
        endcase
`ifdef RV32V_MUL_WIDEN_EN
        case (sew)
            2'b00:   wide_sel = wide8;
            2'b01:   wide_sel = wide16;
            default: wide_sel = wide32;
        endcase
`endif
    end

    // The multiply sits ahead of stage 1 so STAGES=1 still meets the latency;
    // the register chain behind it is left to synthesis retiming.
    logic            valid_q [STAGES];
    logic [DW-1:0]   half_q  [STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];
`ifdef RV32V_MUL_WIDEN_EN
    logic [2*DW-1:0] wide_q  [STAGES];
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: these arrays are a register pipeline, not a RAM, so clearing them on reset is
            // cheap and gives product/tag_out = 0 straight out of reset.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                half_q[k]  <= '0;
                tag_q[k]   <= '0;
`ifdef RV32V_MUL_WIDEN_EN
                wide_q[k]  <= '0;
`endif
            end
        end else if (!stall) begin
            // NOTE: non-blocking assignments make every stage read its predecessor's old value.
            valid_q[0] <= start;
            half_q[0]  <= half_sel;
            tag_q[0]   <= tag_in;
`ifdef RV32V_MUL_WIDEN_EN
            wide_q[0]  <= wide_sel;
`endif
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                half_q[k]  <= half_q[k-1];
                tag_q[k]   <= tag_q[k-1];
`ifdef RV32V_MUL_WIDEN_EN
                wide_q[k]  <= wide_q[k-1];
`endif
            end
        end
    end

    assign finished = valid_q[STAGES-1];
    assign product  = half_q[STAGES-1];
    assign tag_out  = tag_q[STAGES-1];
`ifdef RV32V_MUL_WIDEN_EN
    assign product_wide = wide_q[STAGES-1];
`endif

endmodule

// File: doc/rv32v_simd_multiplier.md
Name: rv32v_simd_multiplier

Overview:
- Pipelined, lane-partitioned integer multiplier for the rv32v vector execute lane.
- Successor to the scalar rv32v_multiplier: same operand/sign conventions, now with SEW-selectable lanes (8/16/32), high/low half select (vmul/vmulh/vmulhu/vmulhsu), parametrised depth, stall and tag passthrough.
- Accepts one operation per cycle; results return in order after a fixed latency.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a multiple of 32.
- STAGES, 3, pipeline depth (latency in cycles); legal range 1..6.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  operation valid; accepted when start=1 and stall=0.
- stall  in  1  freeze whole pipeline, including the output registers.
- multiplicand  in  DATA_WIDTH  operand A, SEW-packed lanes.
- multiplier  in  DATA_WIDTH  operand B, SEW-packed lanes.
- is_signed  in  2  [1]=multiplicand signed, [0]=multiplier signed.
- sew  in  2  00=8b, 01=16b, 10=32b, 11 treated as 32b.
- high_half  in  1  1=return upper SEW bits of each lane product, 0=lower.
- tag_in  in  TAG_W  returned unchanged with the result.
- finished  out  1  result valid, one-cycle pulse per accepted operation.
- product  out  DATA_WIDTH  per-lane selected half, packed at the same lane positions as the operands.
- tag_out  out  TAG_W  tag of the operation in product.

Behaviour:
- Reset (async, nRST=0): finished=0, product=0, tag_out=0; all stage valid bits cleared at once. In-flight operations are discarded and never complete.
- Acceptance: a cycle with start&&!stall captures operands, sew, is_signed, high_half and tag into stage 1. start while stall=1 is ignored; the source must hold it.
- Latency: an op accepted at edge N gives finished=1 after edge N+STAGES-1, i.e. visible in the cycle following that edge, when no stall occurs. Each stall cycle adds one cycle.
- stall=1: every stage register holds, including finished/product/tag_out. A held finished=1 stays asserted and counts as a single result.
- No bubble collapse: valid bits shift with the data, so ordering and spacing are preserved.
- Lanes: DATA_WIDTH/SEW independent lanes. Lane i spans bits [i*SEW +: SEW].
  - Each lane operand is extended by 1 bit: sign-extended if its is_signed bit is set, otherwise zero-extended.
  - The lane product is 2*SEW bits, two's complement, exact.
  - No carries or partial products cross lane boundaries.
- Output half: product lane = low SEW bits when high_half=0, high SEW bits when high_half=1. The low half is independent of is_signed.
- Internals: the implementation is free to use Booth/bitpair recoding spread across stages, provided results are bit-exact.
- Mode mixing: each op carries its own sew/is_signed/high_half. Back-to-back ops with different modes are legal.

Optional Feature:
- RV32V_MUL_WIDEN_EN.
- Defined: adds output product_wide [2*DATA_WIDTH-1:0], valid with finished. It holds each lane's full 2*SEW-bit product, lane i at [i*2*SEW +: 2*SEW]. This serves widening ops (vwmul*).
- Not defined: the port is absent and no wide result is stored. Only the selected half is kept in the last stage.

Test Plan:
- sew=10, A=B=0xFFFFFFFF: is_signed=00, high_half=1 -> 0xFFFFFFFE; same with high_half=0 -> 0x00000001; is_signed=11, high_half=1 -> 0x00000000.
- sew=00, is_signed=11, A=0x80FF0210, B=0x80FF0310: high_half=1 -> 0x40000001; high_half=0 -> 0x00010600. With WIDEN_EN, product_wide=0x4000000100060100.
- sew=01, is_signed=10, A=0xFFFF8000, B=0x00020002: high_half=1 -> 0xFFFFFFFF; high_half=0 -> 0xFFFE0000.
- Streaming: issue tags 1,2,3 on consecutive cycles with STAGES=3 and stall=1 for 2 cycles after the second accept -> finished pulses in order 1,2,3, each tag's latency 3 plus 2 stall cycles. start held during the stall is not double-accepted.
- Reset mid-flight: accept 2 ops, drop nRST asynchronously between clock edges -> finished/product/tag_out are 0 immediately and no result appears after release. The next op completes with normal latency.
- Mixed modes back-to-back: sew=00 op followed by sew=10 op, 0x00000007*0x00000006 unsigned low -> second result 0x0000002A. The first op's lanes are unaffected.
